// File: rtl/axi_lite_pattern_tester_pkg.sv
// Shared types and constants for the AXI4-Lite pattern tester: FSM states,
// pattern mode encodings, response codes and LFSR tap masks.
package axi_lite_tester_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FIN
  } state_t;

  localparam logic [1:0] MODE_INCR  = 2'd0;
  localparam logic [1:0] MODE_WALK1 = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_ADDR  = 2'd3;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Tap masks: bit n-1 set for each x^n term (the +1 term is implicit)
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/axi_lite_pattern_tester_if.sv
// AXI4-Lite bus bundle between the pattern tester (master) and a memory slave.
interface axi_lite_pattern_tester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_lite_pattern_tester_pattern_gen.sv
// Pattern word generator shared by the write and read phases, so the value
// written and the value expected on read-back come from the same sequence.
module pattern_gen
  import axi_lite_tester_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          advance,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] seed,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] word
);

  localparam logic [DW-1:0] TAPS = (DW == 64) ? DW'(LFSR_TAPS_64) : DW'(LFSR_TAPS_32);

  logic [DW-1:0] r_word;
  logic [DW-1:0] w_init;
  logic [DW-1:0] w_next;
  logic          w_fb;

  // A zero seed would lock walking-one and LFSR at zero, so substitute a live value
  always_comb begin
    w_init = seed;
    if (mode == MODE_WALK1 && seed == '0) w_init = DW'(1);
    if (mode == MODE_LFSR && seed == '0) w_init = '1;
  end

  assign w_fb = ^(r_word & TAPS);

  always_comb begin
    w_next = r_word;
    case (mode)
      MODE_INCR:  w_next = r_word + DW'(1);
      MODE_WALK1: w_next = {r_word[DW-2:0], r_word[DW-1]};
      MODE_LFSR:  w_next = {r_word[DW-2:0], w_fb};
      default:    w_next = r_word;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
    end else if (restart) begin
      r_word <= w_init;
    end else if (advance) begin
      r_word <= w_next;
    end
  end

  assign word = (mode == MODE_ADDR) ? DW'(addr) : r_word;

endmodule

// File: rtl/axi_lite_pattern_tester.sv
// AXI4-Lite master that writes a generated pattern to NUM_WORDS words, reads
// them back and reports error count, first failing address and pass/done.
module axi_lite_pattern_tester
  import axi_lite_tester_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int NUM_WORDS          = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int ERR_CNT_WIDTH      = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] seed,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_CNT_WIDTH-1:0]      err_count,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] first_err_addr,
  axi_lite_pattern_tester_if.master     M_AXI
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam logic [AW-1:0] STEP     = AW'(DW / 8);
  localparam logic [15:0]   LAST_IDX = 16'(NUM_WORDS - 1);

  state_t                   r_state;
  logic [1:0]               r_mode;
  logic [DW-1:0]            r_seed;
  logic [AW-1:0]            r_addr;
  logic [15:0]              r_idx;
  logic                     r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic                     r_busy, r_done, r_pass;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;
  logic [AW-1:0]            r_first_err_addr;

  logic [DW-1:0] w_word;
  logic [1:0]    w_gen_mode;
  logic [DW-1:0] w_gen_seed;
  logic          w_b_hs, w_r_hs, w_last, w_err;
  logic          w_restart, w_advance, w_aw_done, w_w_done;

  // In IDLE the generator sees the live inputs so it can restart on the start edge
  assign w_gen_mode = (r_state == IDLE) ? mode : r_mode;
  assign w_gen_seed = (r_state == IDLE) ? seed : r_seed;

  assign w_last    = (r_idx == LAST_IDX);
  assign w_b_hs    = (r_state == WR_RESP) && r_bready && M_AXI.BVALID;
  assign w_r_hs    = (r_state == RD_RESP) && r_rready && M_AXI.RVALID;
  assign w_restart = ((r_state == IDLE) && start) || (w_b_hs && w_last);
  assign w_advance = (w_b_hs && !w_last) || w_r_hs;
  assign w_aw_done = !r_awvalid || M_AXI.AWREADY;
  assign w_w_done  = !r_wvalid || M_AXI.WREADY;
  assign w_err     = (w_b_hs && (M_AXI.BRESP != RESP_OKAY)) ||
                     (w_r_hs && ((M_AXI.RRESP != RESP_OKAY) || (M_AXI.RDATA != w_word)));

  pattern_gen #(.DW(DW), .AW(AW)) u_gen (
    .clk     (ACLK),
    .rst     (ARESET),
    .restart (w_restart),
    .advance (w_advance),
    .mode    (w_gen_mode),
    .seed    (w_gen_seed),
    .addr    (r_addr),
    .word    (w_word)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state          <= IDLE;
      r_mode           <= MODE_INCR;
      r_seed           <= '0;
      r_addr           <= '0;
      r_idx            <= '0;
      r_awvalid        <= 1'b0;
      r_wvalid         <= 1'b0;
      r_bready         <= 1'b0;
      r_arvalid        <= 1'b0;
      r_rready         <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_err_count      <= '0;
      r_first_err_addr <= '0;
    end else begin
      if (w_err) begin
        if (r_err_count == '0) r_first_err_addr <= r_addr;
        if (r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
      end
      case (r_state)
        IDLE: if (start) begin
          r_mode           <= mode;
          r_seed           <= seed;
          r_addr           <= BASE_ADDR;
          r_idx            <= '0;
          r_busy           <= 1'b1;
          r_done           <= 1'b0;
          r_pass           <= 1'b0;
          r_err_count      <= '0;
          r_first_err_addr <= '0;
          r_awvalid        <= 1'b1;
          r_wvalid         <= 1'b1;
          r_state          <= WR_REQ;
        end
        // AW and W retire independently; move on once both have
        WR_REQ: begin
          if (M_AXI.AWREADY) r_awvalid <= 1'b0;
          if (M_AXI.WREADY) r_wvalid <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: if (M_AXI.BVALID) begin
          r_bready <= 1'b0;
          if (w_last) begin
            r_idx     <= '0;
            r_addr    <= BASE_ADDR;
            r_arvalid <= 1'b1;
            r_state   <= RD_REQ;
          end else begin
            r_idx     <= r_idx + 16'd1;
            r_addr    <= r_addr + STEP;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= WR_REQ;
          end
        end
        RD_REQ: if (M_AXI.ARREADY) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_state   <= RD_RESP;
        end
        RD_RESP: if (M_AXI.RVALID) begin
          r_rready <= 1'b0;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err_count == '0) && !w_err;
            r_state <= FIN;
          end else begin
            r_idx     <= r_idx + 16'd1;
            r_addr    <= r_addr + STEP;
            r_arvalid <= 1'b1;
            r_state   <= RD_REQ;
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign M_AXI.AWADDR  = r_addr;
  assign M_AXI.AWPROT  = 3'b000;
  assign M_AXI.AWVALID = r_awvalid;
  assign M_AXI.WDATA   = w_word;
  assign M_AXI.WSTRB   = '1;
  assign M_AXI.WVALID  = r_wvalid;
  assign M_AXI.BREADY  = r_bready;
  assign M_AXI.ARADDR  = r_addr;
  assign M_AXI.ARPROT  = 3'b000;
  assign M_AXI.ARVALID = r_arvalid;
  assign M_AXI.RREADY  = r_rready;

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_axi_lite_pattern_tester.sv
// Scoreboard bench: a memory slave with fault injection, a pattern reference
// model, and a negedge monitor that checks bus traffic and run results.
module tb_axi_lite_pattern_tester;
  import axi_lite_tester_pkg::*;

  localparam int NW = 4;
  localparam logic [31:0] BASE = 32'h0;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  axi_lite_pattern_tester_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  axi_lite_pattern_tester #(
    .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_WORDS(NW),
    .BASE_ADDR(BASE), .ERR_CNT_WIDTH(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .mode(mode), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .M_AXI(axi)
  );

  initial forever #5 ACLK = ~ACLK;

  typedef struct {
    logic [15:0] errs;
    logic [31:0] firstAddr;
    logic        passV;
  } result_t;

  int          nChecks = 0;
  int          nFails = 0;
  logic [31:0] expAwQ[$];
  logic [31:0] expWQ[$];
  logic [31:0] expArQ[$];
  result_t     expResQ[$];

  int          cfgAwDelay = 0, cfgWDelay = 0, cfgRLat = 0;
  bit          wrErrEn = 0, rdOvrEn = 0;
  logic [31:0] wrErrAddr = 0, rdOvrAddr = 0, rdOvrVal = 0;
  bit          wBeforeAw, firstWSeen;
  logic [31:0] firstWData;
  int          awRunCount;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
    end
  endtask

  // Word k of a run straight from the pattern definitions
  function automatic logic [31:0] patWord(input logic [1:0] m, input logic [31:0] s,
                                          input int k, input logic [31:0] addr);
    logic [31:0] v;
    int r;
    case (m)
      MODE_INCR: v = s + 32'(k);
      MODE_WALK1: begin
        v = (s == 0) ? 32'd1 : s;
        r = k % 32;
        v = (v << r) | (v >> (32 - r));
      end
      MODE_LFSR: begin
        v = (s == 0) ? 32'hFFFF_FFFF : s;
        for (int j = 0; j < k; j++) v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
      end
      default: v = addr;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] m, input logic [31:0] s);
    result_t res;
    logic [31:0] a, d, rd;
    res.errs = 0;
    res.firstAddr = 0;
    for (int k = 0; k < NW; k++) begin
      a = BASE + 32'(4 * k);
      d = patWord(m, s, k, a);
      expAwQ.push_back(a);
      expWQ.push_back(d);
      expArQ.push_back(a);
      if (wrErrEn && a == wrErrAddr) begin
        if (res.errs == 0) res.firstAddr = a;
        res.errs++;
      end
    end
    for (int k = 0; k < NW; k++) begin
      a = BASE + 32'(4 * k);
      d = patWord(m, s, k, a);
      rd = (rdOvrEn && a == rdOvrAddr) ? rdOvrVal : d;
      if (rd != d) begin
        if (res.errs == 0) res.firstAddr = a;
        res.errs++;
      end
    end
    res.passV = (res.errs == 0);
    expResQ.push_back(res);
    wBeforeAw = 0;
    firstWSeen = 0;
    awRunCount = 0;
    @(posedge ACLK); #1;
    mode = m; seed = s; start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    seed = $urandom;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput({name, "_done"}, 64'(done), 64'd1);
    repeat (3) @(negedge ACLK);
  endtask

  // Memory slave with configurable READY delays, read latency and faults
  initial begin
    logic [31:0] mem [0:15];
    bit awHs, wHs, bHs, arHs, rHs, gotAw, gotW, rPend;
    logic [31:0] awA, wD, arA, wrAddr, wrData, rAddr;
    int awCnt, wCnt, rWait;
    for (int i = 0; i < 16; i++) mem[i] = 0;
    gotAw = 0; gotW = 0; rPend = 0; awCnt = 0; wCnt = 0; rWait = 0;
    wrAddr = 0; wrData = 0; rAddr = 0;
    axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
    axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
    forever begin
      @(negedge ACLK);
      awHs = axi.AWVALID && axi.AWREADY;
      wHs  = axi.WVALID && axi.WREADY;
      bHs  = axi.BVALID && axi.BREADY;
      arHs = axi.ARVALID && axi.ARREADY;
      rHs  = axi.RVALID && axi.RREADY;
      awA = axi.AWADDR; wD = axi.WDATA; arA = axi.ARADDR;
      @(posedge ACLK); #1;
      if (ARESET) begin
        gotAw = 0; gotW = 0; rPend = 0; awCnt = 0; wCnt = 0;
        axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0;
        axi.ARREADY = 0; axi.RVALID = 0;
        continue;
      end
      if (awHs) begin gotAw = 1; wrAddr = awA; awCnt = 0; end
      if (wHs) begin gotW = 1; wrData = wD; wCnt = 0; end
      if (bHs) axi.BVALID = 0;
      if (gotAw && gotW && !axi.BVALID) begin
        mem[wrAddr[5:2]] = wrData;
        axi.BRESP = (wrErrEn && wrAddr == wrErrAddr) ? 2'b10 : 2'b00;
        axi.BVALID = 1;
        gotAw = 0; gotW = 0;
      end
      if (axi.AWVALID && !gotAw) begin axi.AWREADY = (awCnt >= cfgAwDelay); awCnt++; end
      else axi.AWREADY = 0;
      if (axi.WVALID && !gotW) begin axi.WREADY = (wCnt >= cfgWDelay); wCnt++; end
      else axi.WREADY = 0;
      if (rHs) axi.RVALID = 0;
      if (arHs) begin rPend = 1; rWait = cfgRLat; rAddr = arA; end
      if (rPend && !axi.RVALID) begin
        if (rWait == 0) begin
          axi.RDATA = (rdOvrEn && rAddr == rdOvrAddr) ? rdOvrVal : mem[rAddr[5:2]];
          axi.RRESP = 2'b00;
          axi.RVALID = 1;
          rPend = 0;
        end else rWait--;
      end
      axi.ARREADY = axi.ARVALID && !rPend && !axi.RVALID;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a handshake or a run
  initial begin
    bit prevDone;
    result_t res;
    prevDone = 0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin prevDone = 0; continue; end
      if (axi.AWVALID && axi.AWREADY) begin
        awRunCount++;
        if (expAwQ.size() == 0) begin
          nChecks++; nFails++;
          $display("[TB] FAIL aw_unexpected: got addr 0x%0h, want no write", axi.AWADDR);
        end else checkOutput("aw_addr", 64'(axi.AWADDR), 64'(expAwQ.pop_front()));
      end
      if (axi.WVALID && axi.WREADY) begin
        if (axi.AWVALID && !axi.AWREADY) wBeforeAw = 1;
        if (!firstWSeen) begin firstWData = axi.WDATA; firstWSeen = 1; end
        if (expWQ.size() == 0) begin
          nChecks++; nFails++;
          $display("[TB] FAIL w_unexpected: got data 0x%0h, want no write", axi.WDATA);
        end else checkOutput("w_data", 64'(axi.WDATA), 64'(expWQ.pop_front()));
      end
      if (axi.ARVALID && axi.ARREADY) begin
        if (expArQ.size() == 0) begin
          nChecks++; nFails++;
          $display("[TB] FAIL ar_unexpected: got addr 0x%0h, want no read", axi.ARADDR);
        end else checkOutput("ar_addr", 64'(axi.ARADDR), 64'(expArQ.pop_front()));
      end
      if (done && !prevDone) begin
        if (expResQ.size() == 0) begin
          nChecks++; nFails++;
          $display("[TB] FAIL done_unexpected: got done=1, want no run");
        end else begin
          res = expResQ.pop_front();
          checkOutput("err_count", 64'(err_count), 64'(res.errs));
          checkOutput("first_err_addr", 64'(first_err_addr), 64'(res.firstAddr));
          checkOutput("pass", 64'(pass), 64'(res.passV));
          checkOutput("busy_at_done", 64'(busy), 64'd0);
          checkOutput("write_count", 64'(awRunCount), 64'(NW));
        end
      end
      prevDone = done;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no end of test, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    ARESET = 1; start = 0; mode = 0; seed = 0;
    repeat (3) @(negedge ACLK);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pass", 64'(pass), 64'd0);
    checkOutput("rst_err_count", 64'(err_count), 64'd0);
    checkOutput("rst_first_err_addr", 64'(first_err_addr), 64'd0);
    checkOutput("rst_handshakes", 64'({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}), 64'd0);
    checkOutput("rst_addrs", 64'({axi.AWADDR, axi.ARADDR}), 64'd0);
    checkOutput("rst_wdata", 64'(axi.WDATA), 64'd0);
    checkOutput("rst_prot", 64'({axi.AWPROT, axi.ARPROT}), 64'd0);
    checkOutput("rst_wstrb", 64'(axi.WSTRB), 64'hF);
    ARESET = 0;

    $display("[TB] incrementing pattern, ideal slave");
    applyStimulus(MODE_INCR, 32'd1);
    waitDone("incr");

    $display("[TB] AWREADY held low 3 cycles");
    cfgAwDelay = 3;
    applyStimulus(MODE_INCR, 32'h100);
    waitDone("aw_delay");
    checkOutput("w_before_aw", 64'(wBeforeAw), 64'd1);
    cfgAwDelay = 0;

    $display("[TB] corrupted read at 0x8");
    rdOvrEn = 1; rdOvrAddr = 32'h8; rdOvrVal = 32'hDEAD;
    applyStimulus(MODE_INCR, 32'd1);
    waitDone("rd_corrupt");

    $display("[TB] SLVERR on write 0x4, zero read at 0xC");
    wrErrEn = 1; wrErrAddr = 32'h4; rdOvrAddr = 32'hC; rdOvrVal = 32'h0;
    applyStimulus(MODE_INCR, 32'd1);
    waitDone("two_errors");
    wrErrEn = 0; rdOvrEn = 0;

    $display("[TB] LFSR with zero seed");
    applyStimulus(MODE_LFSR, 32'd0);
    waitDone("lfsr");
    checkOutput("lfsr_first_word", 64'(firstWData), 64'hFFFF_FFFF);

    $display("[TB] reset during read response of word 2");
    cfgRLat = 6;
    applyStimulus(MODE_WALK1, 32'h8000_0001);
    n = 0;
    while (!(axi.ARVALID && axi.ARREADY && axi.ARADDR == 32'h8) && n < 500) begin
      @(negedge ACLK);
      n++;
    end
    checkOutput("abort_reached_word2", 64'(axi.ARADDR), 64'h8);
    @(negedge ACLK);
    checkOutput("abort_rready_before", 64'(axi.RREADY), 64'd1);
    #2 ARESET = 1;
    #1;
    checkOutput("abort_handshakes", 64'({axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY}), 64'd0);
    checkOutput("abort_busy_done", 64'({busy, done}), 64'd0);
    expAwQ.delete(); expWQ.delete(); expArQ.delete(); expResQ.delete();
    repeat (2) @(negedge ACLK);
    ARESET = 0;
    cfgRLat = 0;
    applyStimulus(MODE_LFSR, 32'h1234_5678);
    waitDone("after_abort");

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      cfgAwDelay = $urandom_range(0, 2);
      cfgWDelay  = $urandom_range(0, 2);
      cfgRLat    = $urandom_range(0, 2);
      applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      waitDone("random");
    end

    repeat (5) @(negedge ACLK);
    checkOutput("results_drained", 64'(expResQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/axi_lite_pattern_tester.md
Name: axi_lite_pattern_tester

Overview:
- Synthesizable AXI4-Lite master that writes a generated data pattern to NUM_WORDS consecutive word addresses, then reads them back and checks each word.
- Successor to the bench-only sequential write/read-compare check of the BRAM cache slave, for on-chip and regression self-test.
- Adds parametrised width, depth and base address, four pattern modes, response checking, error counting and first-error capture.
- Sits in the block design as the master on the cache slave's S00_AXI port.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width; only 32 and 64 are legal.
- NUM_WORDS, 4, words per run; range 1..65535.
- BASE_ADDR, 0, first byte address; must be aligned to C_M_AXI_DATA_WIDTH/8.
- ERR_CNT_WIDTH, 16, width of the error counter.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; ignored while busy=1.
- mode  in  2  pattern select: 0 incrementing, 1 walking-one, 2 LFSR, 3 address-as-data.
- seed  in  C_M_AXI_DATA_WIDTH  pattern seed; sampled when start is accepted.
- busy  out  1  a run is in progress.
- done  out  1  high from the end of a run until the next accepted start.
- pass  out  1  done and err_count==0.
- err_count  out  ERR_CNT_WIDTH  errors in the current run; saturates at all-ones.
- first_err_addr  out  C_M_AXI_ADDR_WIDTH  address of the first error in the run.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels; widths follow the parameters; WSTRB is DATA_WIDTH/8 bits.

Behaviour:
- Reset values: every VALID and READY output 0; busy, done, pass 0; err_count 0; first_err_addr 0; addresses and WDATA 0; AWPROT and ARPROT always 3'b000; WSTRB always all-ones.
- Reset asserted mid-run: all VALIDs drop immediately (asynchronously) and the FSM returns to IDLE. No run is resumed.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FIN.
- IDLE: start=1 -> WR_REQ next cycle. On entry:
  - busy=1, done=0; err_count and first_err_addr cleared;
  - seed latched and the generator restarted; word index i=0.
- WR_REQ:
  - AWVALID and WVALID rise in the same cycle, carrying address BASE_ADDR + i*(DATA_WIDTH/8) and the current pattern word.
  - Each VALID falls independently on its own handshake.
  - Exit to WR_RESP when both handshakes are done; they may complete in the same cycle or in either order.
  - ADDR and DATA stay stable while VALID is high.
- WR_RESP: BREADY=1. On BVALID:
  - BRESP != OKAY counts as one error;
  - generator advances, i increments;
  - if i was NUM_WORDS-1: generator restarts, i=0, go to RD_REQ; otherwise go to WR_REQ.
- RD_REQ: ARVALID with the same address sequence; go to RD_RESP on the ARREADY handshake.
- RD_RESP: RREADY=1. On RVALID:
  - RRESP != OKAY or RDATA != expected word counts as exactly one error, even if both conditions hold;
  - generator advances, i increments;
  - last word -> FIN.
- FIN: busy=0, done=1 and pass updated in the same cycle; return to IDLE.
- Transactions: at most one outstanding; minimum 3 cycles per word with zero-wait-state READYs.
- Address arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is silent.
- Error capture:
  - first_err_addr is loaded only when err_count==0 before the increment.
  - err_count saturates at all-ones; a further error holds the value.
- Patterns (word k, with s = latched seed):
  - mode 0: s+k, modulo 2^DATA_WIDTH.
  - mode 1: s rotated left by k. If s==0, 1 is used instead.
  - mode 2: Fibonacci LFSR that steps once per word.
    - Taps: x^32+x^22+x^2+x+1 for 32-bit data; x^64+x^63+x^61+x^60+1 for 64-bit data.
    - If s==0, all-ones is used instead.
  - mode 3: the zero-extended or truncated byte address of the word.
- mode changes while busy have no effect; mode is latched at start.

Decomposition:
- Package axi_lite_tester_pkg holds:
  - the state enum;
  - mode encodings (MODE_INCR, MODE_WALK1, MODE_LFSR, MODE_ADDR);
  - RESP_OKAY = 2'b00;
  - the LFSR tap constants for 32- and 64-bit data.
- Sub-module pattern_gen: ports restart, advance, mode, seed and addr; output word. Used for both the write phase and the read phase, which keeps the expected values identical by construction.

Test Plan:
- mode 0, seed 1, NUM_WORDS 4, BASE 0, ideal slave -> writes 1,2,3,4 to 0x0,0x4,0x8,0xC; reads match; done=1, pass=1, err_count=0.
- Slave holds AWREADY low 3 cycles while WREADY=1 -> W handshake completes first, AW completes later; exactly 4 write transactions and pass=1.
- Slave corrupts the read at 0x8 to 0xDEAD -> err_count=1, first_err_addr=0x8, pass=0.
- Slave returns SLVERR on the write to 0x4 and data 0 at 0xC -> err_count=2, first_err_addr=0x4.
- mode 2, seed 0 -> first written word 0xFFFFFFFF, the LFSR sequence is verified against a bench model, pass=1.
- ARESET pulsed during RD_RESP of word 2 -> all VALIDs low immediately, busy=0, done=0; a new start completes with pass=1.
